// File: rtl/ap_sched_pkg.sv
// Shared types and defaults for the MFCC frame scheduler.
// Holds the FSM state encoding, the default parameter values and
// the width helpers used to size the slot and timeout counters.
package ap_sched_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRIME    = 3'd1,
    WAIT_HOP = 3'd2,
    PROC     = 3'd3,
    DONE     = 3'd4
  } ap_state_e;

  localparam int DEF_FRAME_LEN     = 256;
  localparam int DEF_HOP_LEN       = 128;
  localparam int DEF_N_FEAT_FRAMES = 13;
  localparam int DEF_PROC_TIMEOUT  = 2048;
  localparam int OVR_CNT_W         = 8;

  // Slot counter width: enough bits to index N feature slots.
  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Timeout counter width: must be able to hold the limit value itself.
  function automatic int tmo_w(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/ap_frame_scheduler_if.sv
// Control bus between the scheduler and its environment.
// master = pipeline/classifier side driving the inputs, slave = scheduler.
interface ap_frame_scheduler_if;

  logic       enable;
  logic       sample_valid;
  logic       proc_done;
  logic       vec_ready;
  logic       proc_start;
  logic [3:0] slot_idx;
  logic       vec_valid;
  logic       busy;
  logic       overrun;
  logic       timeout_err;
  logic [7:0] overrun_cnt;

  modport master (
    output enable, sample_valid, proc_done, vec_ready,
    input  proc_start, slot_idx, vec_valid, busy, overrun, timeout_err, overrun_cnt
  );

  modport slave (
    input  enable, sample_valid, proc_done, vec_ready,
    output proc_start, slot_idx, vec_valid, busy, overrun, timeout_err, overrun_cnt
  );

endinterface

// File: rtl/ap_frame_scheduler_hop_counter.sv
// Sample counter that produces a registered one-cycle hop_tick each time
// HOP_LEN samples have been seen. i_clear restarts the count.
module ap_hop_counter #(
  parameter int HOP_LEN = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_sample_valid,
  output logic o_hop_tick
);

  localparam int CNT_W = (HOP_LEN > 1) ? $clog2(HOP_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOP_LEN - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_hop_tick;

  // Count samples; wrap and raise hop_tick for exactly one cycle.
  always_ff @(posedge clk) begin
    if (!rst || i_clear) begin
      r_cnt      <= '0;
      r_hop_tick <= 1'b0;
    end else begin
      r_hop_tick <= 1'b0;
      if (i_sample_valid) begin
        if (r_cnt == CNT_LAST) begin
          r_cnt      <= '0;
          r_hop_tick <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_hop_tick = r_hop_tick;

endmodule

// File: rtl/ap_frame_scheduler.sv
// MFCC front-end frame scheduler: paces the pipeline from hop ticks,
// tracks feature slots, hands the full vector to the classifier and
// flags dropped hops and stuck processing.
// Optional feature: define AP_SCHED_OVR_CNT_EN for a saturating
// dropped-hop counter on overrun_cnt; otherwise it reads 0.
module ap_frame_scheduler
  import ap_sched_pkg::*;
#(
  parameter int FRAME_LEN     = DEF_FRAME_LEN,
  parameter int HOP_LEN       = DEF_HOP_LEN,
  parameter int N_FEAT_FRAMES = DEF_N_FEAT_FRAMES,
  parameter int PROC_TIMEOUT  = DEF_PROC_TIMEOUT
) (
  input logic                 clk,
  input logic                 rst,
  ap_frame_scheduler_if.slave bus
);

  localparam int PRIME_HOPS = FRAME_LEN / HOP_LEN;
  localparam int PRIME_W    = $clog2(PRIME_HOPS + 1);
  localparam int SLOT_W     = slot_w(N_FEAT_FRAMES);
  localparam int TMO_W      = tmo_w(PROC_TIMEOUT);

  localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(PRIME_HOPS - 1);
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(N_FEAT_FRAMES - 1);
  localparam logic [TMO_W-1:0]   TMO_LIMIT  = TMO_W'(PROC_TIMEOUT);

  localparam logic [2:0] S_IDLE     = IDLE;
  localparam logic [2:0] S_PRIME    = PRIME;
  localparam logic [2:0] S_WAIT_HOP = WAIT_HOP;
  localparam logic [2:0] S_PROC     = PROC;
  localparam logic [2:0] S_DONE     = DONE;

  logic [2:0]         r_state, w_state_next;
  logic [SLOT_W-1:0]  r_slot, w_slot_next;
  logic [PRIME_W-1:0] r_prime, w_prime_next;
  logic [TMO_W-1:0]   r_tmo, w_tmo_next, w_tmo_inc;
  logic               r_overrun, r_timeout_err;
  logic               w_hop_tick, w_hop_clear;
  logic               w_proc_start, w_drop, w_tmo_fire;

  assign w_hop_clear = !bus.enable;
  assign w_tmo_inc   = r_tmo + TMO_W'(1);

  ap_hop_counter #(
    .HOP_LEN        (HOP_LEN)
  ) u_hop_counter (
    .clk            (clk),
    .rst            (rst),
    .i_clear        (w_hop_clear),
    .i_sample_valid (bus.sample_valid),
    .o_hop_tick     (w_hop_tick)
  );

  // Next-state, slot/prime/timeout counter updates and per-cycle events.
  // Timer is loaded with 1 on proc_start so it equals cycles since the start.
  always_comb begin
    w_state_next = r_state;
    w_slot_next  = r_slot;
    w_prime_next = r_prime;
    w_tmo_next   = r_tmo;
    w_proc_start = 1'b0;
    w_drop       = 1'b0;
    w_tmo_fire   = 1'b0;
    if (!bus.enable) begin
      w_state_next = S_IDLE;
      w_slot_next  = '0;
      w_prime_next = '0;
      w_tmo_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_next = S_PRIME;
          w_prime_next = '0;
        end
        S_PRIME: begin
          if (w_hop_tick) begin
            if (r_prime == PRIME_LAST) begin
              w_proc_start = 1'b1;
              w_state_next = S_PROC;
              w_prime_next = '0;
              w_tmo_next   = TMO_W'(1);
            end else begin
              w_prime_next = r_prime + PRIME_W'(1);
            end
          end
        end
        S_WAIT_HOP: begin
          if (w_hop_tick) begin
            w_proc_start = 1'b1;
            w_state_next = S_PROC;
            w_tmo_next   = TMO_W'(1);
          end
        end
        S_PROC: begin
          if (bus.proc_done) begin
            if (r_slot == SLOT_LAST) begin
              // Vector complete; a coincident hop has nowhere to go.
              w_slot_next  = '0;
              w_state_next = S_DONE;
              w_drop       = w_hop_tick;
              w_tmo_next   = '0;
            end else begin
              w_slot_next = r_slot + SLOT_W'(1);
              if (w_hop_tick) begin
                // Pipeline frees up exactly on the hop: start the next frame.
                w_proc_start = 1'b1;
                w_tmo_next   = TMO_W'(1);
              end else begin
                w_state_next = S_WAIT_HOP;
                w_tmo_next   = '0;
              end
            end
          end else begin
            w_drop = w_hop_tick;
            if (w_tmo_inc == TMO_LIMIT) begin
              w_tmo_fire   = 1'b1;
              w_state_next = S_WAIT_HOP;
              w_tmo_next   = '0;
            end else begin
              w_tmo_next = w_tmo_inc;
            end
          end
        end
        S_DONE: begin
          w_drop = w_hop_tick;
          if (bus.vec_ready) begin
            w_state_next = S_WAIT_HOP;
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // State, counters and sticky error flags; only rst clears the flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_slot        <= '0;
      r_prime       <= '0;
      r_tmo         <= '0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_slot  <= w_slot_next;
      r_prime <= w_prime_next;
      r_tmo   <= w_tmo_next;
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
      if (w_tmo_fire) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

`ifdef AP_SCHED_OVR_CNT_EN
  logic [OVR_CNT_W-1:0] r_ovr_cnt;

  // Saturating count of dropped hops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ovr_cnt <= '0;
    end else if (w_drop && (r_ovr_cnt != {OVR_CNT_W{1'b1}})) begin
      r_ovr_cnt <= r_ovr_cnt + OVR_CNT_W'(1);
    end
  end

  assign bus.overrun_cnt = r_ovr_cnt;
`else
  assign bus.overrun_cnt = '0;
`endif

  assign bus.proc_start  = w_proc_start;
  assign bus.slot_idx    = 4'(r_slot);
  assign bus.vec_valid   = (r_state == S_DONE);
  assign bus.busy        = (r_state == S_PROC);
  assign bus.overrun     = r_overrun;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_ap_frame_scheduler.sv
// Directed testbench for ap_frame_scheduler: startup, steady state,
// coincidence, overrun, timeout and abort scenarios.
module tb_ap_frame_scheduler;

  logic clk;
  logic rst;

  ap_frame_scheduler_if bus ();

  ap_frame_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;
  int cyc_n;
  int sp;
  int n_samp;
  int samp256_cyc;
  int done_at;
  int done_delay;
  int n_done;
  int n_start;
  int last_start_cyc;
  int start_cyc [16];

  function automatic int exp_cnt(input int n);
`ifdef AP_SCHED_OVR_CNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc_n);
    end else begin
      $display("  ok   %s = %0d (cycle %0d)", tag, act, cyc_n);
    end
  endtask

  // One clock: drive sample/proc_done for the new cycle, then observe proc_start.
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    bus.sample_valid = (sp > 0) && ((cyc_n % sp) == 0);
    if (bus.sample_valid) begin
      n_samp++;
      if (n_samp == 256) samp256_cyc = cyc_n;
    end
    bus.proc_done = (cyc_n == done_at);
    if (bus.proc_done) n_done++;
    #1;
    if (bus.proc_start) begin
      if (n_start < 16) start_cyc[n_start] = cyc_n;
      n_start++;
      last_start_cyc = cyc_n;
      if (done_delay > 0) done_at = cyc_n + done_delay;
    end
  endtask

  task automatic disable_run();
    bus.enable = 1'b0;
    sp         = 0;
    done_at    = -1;
    done_delay = 0;
    cyc();
    cyc();
  endtask

  task automatic start_run(input int period, input int delay);
    n_samp     = 0;
    n_start    = 0;
    n_done     = 0;
    sp         = period;
    done_delay = delay;
    bus.enable = 1'b1;
  endtask

  initial begin
    int found;
    int hold;
    int s1;
    int ns;
    n_vec = 0; n_bad = 0; cyc_n = 0;
    sp = 0; n_samp = 0; samp256_cyc = -1;
    done_at = -1; done_delay = 0; n_done = 0; n_start = 0; last_start_cyc = -1;
    for (int i = 0; i < 16; i++) start_cyc[i] = -1;
    rst = 1'b0;
    bus.enable = 1'b0; bus.sample_valid = 1'b0; bus.proc_done = 1'b0; bus.vec_ready = 1'b0;

    // Reset state
    repeat (3) cyc();
    chk("rst_proc_start", 32'(bus.proc_start), 0);
    chk("rst_slot_idx", 32'(bus.slot_idx), 0);
    chk("rst_vec_valid", 32'(bus.vec_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_overrun", 32'(bus.overrun), 0);
    chk("rst_timeout_err", 32'(bus.timeout_err), 0);
    chk("rst_overrun_cnt", 32'(bus.overrun_cnt), 0);
    rst = 1'b1;
    cyc();

    // 1 Startup, sample period 4
    start_run(4, 300);
    for (int i = 0; i < 1500 && n_start == 0; i++) cyc();
    chk("t1_start_seen", 32'(n_start), 1);
    chk("t1_samples_at_start", 32'(n_samp), 256);
    chk("t1_start_latency", 32'(last_start_cyc - samp256_cyc), 1);
    chk("t1_slot_idx", 32'(bus.slot_idx), 0);
    cyc();
    chk("t1_busy", 32'(bus.busy), 1);

    // 2 Steady state: done 300 cycles after each start
    for (int i = 0; i < 8000 && bus.vec_valid !== 1'b1; i++) cyc();
    chk("t2_vec_valid", 32'(bus.vec_valid), 1);
    chk("t2_done_count", 32'(n_done), 13);
    chk("t2_start_period", 32'(start_cyc[1] - start_cyc[0]), 512);
    chk("t2_start_span", 32'(start_cyc[12] - start_cyc[0]), 6144);
    chk("t2_overrun", 32'(bus.overrun), 0);
    chk("t2_busy_in_done", 32'(bus.busy), 0);
    hold = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (bus.vec_valid === 1'b1) hold++;
    end
    chk("t2_vec_hold", 32'(hold), 100);
    bus.vec_ready = 1'b1;
    cyc();
    bus.vec_ready = 1'b0;
    chk("t2_vec_valid_drop", 32'(bus.vec_valid), 0);
    chk("t2_slot_wrap", 32'(bus.slot_idx), 0);
    disable_run();

    // 4 Coincidence: proc_done lands on every hop_tick
    start_run(1, 128);
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      cyc();
      if (bus.proc_done === 1'b1 && n_done == 5) found = 1;
    end
    chk("t4_coincidence_seen", 32'(found), 1);
    chk("t4_proc_start_same_cycle", 32'(bus.proc_start), 1);
    chk("t4_slot_before", 32'(bus.slot_idx), 4);
    cyc();
    chk("t4_slot_after", 32'(bus.slot_idx), 5);
    chk("t4_busy", 32'(bus.busy), 1);
    chk("t4_no_overrun", 32'(bus.overrun), 0);
    disable_run();

    // 3 Overrun: period 1, done 200 cycles after start
    start_run(1, 200);
    for (int i = 0; i < 600 && n_start == 0; i++) cyc();
    chk("t3_start_seen", 32'(n_start), 1);
    s1 = last_start_cyc;
    for (int i = 0; i < 200 && cyc_n < s1 + 130; i++) cyc();
    chk("t3_no_extra_start", 32'(n_start), 1);
    chk("t3_overrun", 32'(bus.overrun), 1);
    chk("t3_overrun_cnt", 32'(bus.overrun_cnt), 32'(exp_cnt(1)));
    chk("t3_still_busy", 32'(bus.busy), 1);
    disable_run();

    // 5 Timeout: one done at slot 0, then the next frame never completes
    start_run(1, 10);
    for (int i = 0; i < 800 && n_start < 2; i++) begin
      cyc();
      if (n_done >= 1) done_delay = 0;
    end
    chk("t5_second_start", 32'(n_start), 2);
    chk("t5_no_timeout_yet", 32'(bus.timeout_err), 0);
    s1 = last_start_cyc;
    for (int i = 0; i < 2200 && bus.timeout_err !== 1'b1; i++) cyc();
    chk("t5_timeout_latency", 32'(cyc_n - s1), 2048);
    chk("t5_slot_kept", 32'(bus.slot_idx), 1);
    chk("t5_restart_on_hop", 32'(last_start_cyc - s1), 2048);
    cyc();
    chk("t5_busy_again", 32'(bus.busy), 1);

    // 6 Abort mid-PROC, then reset clears sticky flags
    ns = n_start;
    bus.enable = 1'b0;
    sp = 0;
    done_at = -1;
    cyc();
    chk("t6_idle", 32'(bus.busy), 0);
    chk("t6_slot_cleared", 32'(bus.slot_idx), 0);
    chk("t6_overrun_kept", 32'(bus.overrun), 1);
    chk("t6_timeout_kept", 32'(bus.timeout_err), 1);
    chk("t6_overrun_cnt", 32'(bus.overrun_cnt), 32'(exp_cnt(16)));
    repeat (5) cyc();
    chk("t6_no_start", 32'(n_start - ns), 0);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("t6_rst_overrun", 32'(bus.overrun), 0);
    chk("t6_rst_timeout", 32'(bus.timeout_err), 0);
    chk("t6_rst_overrun_cnt", 32'(bus.overrun_cnt), 0);
    chk("t6_rst_vec_valid", 32'(bus.vec_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
